// File: rtl/wb_ddr3_arbiter_pkg.sv
// Shared types and constants for the two-master DDR3 Wishbone arbiter.
// The watchdog is built only when WB_ARB_TIMEOUT_EN is defined.
package platform_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Counter width that can hold the value MAX_OUTSTANDING itself.
  function automatic int outstanding_w(input int max_out);
    return $clog2(max_out) + 1;
  endfunction

endpackage

// File: rtl/wb_ddr3_arbiter_if.sv
// Pipelined Wishbone bus bundle with master/slave modports.
// Handshake: a request transfers on a cycle with cyc & stb & ~stall; every transfer completes with exactly one of ack/err/rty in a later cycle while cyc stays high.
interface wishbone_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [ADDRESS_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   sel;
  logic                      stall;
  logic                      ack;
  logic                      err;
  logic                      rty;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  stall, ack, err, rty, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output stall, ack, err, rty, rdata
  );
endinterface

// File: rtl/wb_ddr3_arbiter_tracker.sv
// Outstanding-request counter for the current grant: full flag, underflow guard,
// and (with WB_ARB_TIMEOUT_EN) a no-response watchdog.
module wb_outstanding_tracker
  import platform_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic in_grant,
  input  logic accept,
  input  logic resp,
  output logic full,
  output logic resp_ok
`ifdef WB_ARB_TIMEOUT_EN
  ,output logic timeout
`endif
);
  localparam int CW = outstanding_w(MAX_OUTSTANDING);

  logic [CW-1:0] count;

  // A response with nothing outstanding belongs to an aborted grant.
  assign resp_ok = resp & (count != '0);
  assign full    = (count == CW'(MAX_OUTSTANDING));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (accept && !resp_ok) begin
      count <= count + CW'(1);
    end else if (!accept && resp_ok) begin
      count <= count - CW'(1);
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] wd_count;
  logic          wd_run;

  assign wd_run  = in_grant & (count != '0) & ~resp;
  assign timeout = wd_run & (wd_count == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_count <= '0;
    end else if (!wd_run || timeout) begin
      wd_count <= '0;
    end else begin
      wd_count <= wd_count + TW'(1);
    end
  end
`endif

endmodule

// File: rtl/wb_ddr3_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter in front of the DDR3 upsizer.
// Round-robin grant held for a whole cyc; WB_ARB_TIMEOUT_EN adds a watchdog and timeout_o.
module wb_ddr3_arbiter
  import platform_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  wishbone_if.slave   m0_wb_if,
  wishbone_if.slave   m1_wb_if,
  wishbone_if.master  s_wb_if,
  output logic [1:0]  grant_o
`ifdef WB_ARB_TIMEOUT_EN
  ,output logic       timeout_o
`endif
);
  arb_state_t state;
  logic       last_owner;
  logic       in_grant;
  logic       own_cyc;
  logic       release_now;
  logic       clear;
  logic       accept;
  logic       resp;
  logic       full;
  logic       resp_ok;
  logic       timeout;

  assign in_grant    = (state != IDLE);
  assign own_cyc     = (state == GRANT1) ? m1_wb_if.cyc : m0_wb_if.cyc;
  assign release_now = in_grant & (~own_cyc | timeout);
  assign clear       = ~in_grant | release_now;
  assign accept      = s_wb_if.stb & ~s_wb_if.stall;
  assign resp        = s_wb_if.ack | s_wb_if.err | s_wb_if.rty;

  wb_outstanding_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) u_tracker (
    .clk      (clk_i),
    .rst_n    (rstn_i),
    .clear    (clear),
    .in_grant (in_grant),
    .accept   (accept),
    .resp     (resp),
    .full     (full),
    .resp_ok  (resp_ok)
`ifdef WB_ARB_TIMEOUT_EN
    ,.timeout (timeout)
`endif
  );

`ifdef WB_ARB_TIMEOUT_EN
  assign timeout_o = timeout;
`else
  assign timeout = 1'b0;
`endif

  // Ties between simultaneous requesters go to whoever did not own the bus last.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      grant_o    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (m0_wb_if.cyc && (!m1_wb_if.cyc || last_owner)) begin
            state      <= GRANT0;
            last_owner <= 1'b0;
            grant_o    <= 2'b01;
          end else if (m1_wb_if.cyc) begin
            state      <= GRANT1;
            last_owner <= 1'b1;
            grant_o    <= 2'b10;
          end
        end
        GRANT0, GRANT1: begin
          if (release_now) begin
            state   <= IDLE;
            grant_o <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    s_wb_if.cyc    = 1'b0;
    s_wb_if.stb    = 1'b0;
    s_wb_if.we     = 1'b0;
    s_wb_if.addr   = '0;
    s_wb_if.wdata  = '0;
    s_wb_if.sel    = '0;
    m0_wb_if.stall = 1'b1;
    m0_wb_if.ack   = 1'b0;
    m0_wb_if.err   = 1'b0;
    m0_wb_if.rty   = 1'b0;
    m0_wb_if.rdata = '0;
    m1_wb_if.stall = 1'b1;
    m1_wb_if.ack   = 1'b0;
    m1_wb_if.err   = 1'b0;
    m1_wb_if.rty   = 1'b0;
    m1_wb_if.rdata = '0;
    if (state == GRANT0) begin
      s_wb_if.cyc    = m0_wb_if.cyc & ~timeout;
      s_wb_if.stb    = m0_wb_if.cyc & m0_wb_if.stb & ~full & ~timeout;
      s_wb_if.we     = m0_wb_if.we;
      s_wb_if.addr   = m0_wb_if.addr;
      s_wb_if.wdata  = m0_wb_if.wdata;
      s_wb_if.sel    = m0_wb_if.sel;
      m0_wb_if.stall = s_wb_if.stall | full;
      m0_wb_if.ack   = s_wb_if.ack & resp_ok;
      m0_wb_if.err   = (s_wb_if.err & resp_ok) | timeout;
      m0_wb_if.rty   = s_wb_if.rty & resp_ok;
      m0_wb_if.rdata = s_wb_if.rdata;
    end else if (state == GRANT1) begin
      s_wb_if.cyc    = m1_wb_if.cyc & ~timeout;
      s_wb_if.stb    = m1_wb_if.cyc & m1_wb_if.stb & ~full & ~timeout;
      s_wb_if.we     = m1_wb_if.we;
      s_wb_if.addr   = m1_wb_if.addr;
      s_wb_if.wdata  = m1_wb_if.wdata;
      s_wb_if.sel    = m1_wb_if.sel;
      m1_wb_if.stall = s_wb_if.stall | full;
      m1_wb_if.ack   = s_wb_if.ack & resp_ok;
      m1_wb_if.err   = (s_wb_if.err & resp_ok) | timeout;
      m1_wb_if.rty   = s_wb_if.rty & resp_ok;
      m1_wb_if.rdata = s_wb_if.rdata;
    end
  end

endmodule

// File: tb/tb_wb_ddr3_arbiter.sv
// Directed bench for wb_ddr3_arbiter: grant order, pipelined reads, outstanding limit,
// stale-ack discard, async reset, and the WB_ARB_TIMEOUT_EN watchdog when built with it.
module tb_wb_ddr3_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  grant;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
`ifdef WB_ARB_TIMEOUT_EN
  logic        timeout;
`endif

  always #5 clk = ~clk;

  wishbone_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
  wishbone_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
  wishbone_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) s_bus ();

  wb_ddr3_arbiter #(
    .ADDRESS_WIDTH   (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (8),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .m0_wb_if  (m0_bus.slave),
    .m1_wb_if  (m1_bus.slave),
    .s_wb_if   (s_bus.master),
    .grant_o   (grant)
`ifdef WB_ARB_TIMEOUT_EN
    ,.timeout_o (timeout)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.sel = '0;
    m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.sel = '0;
    s_bus.stall = 0; s_bus.ack = 0; s_bus.err = 0; s_bus.rty = 0; s_bus.rdata = '0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.we = 1; m0_bus.addr = 32'h1234_5678; m0_bus.wdata = 32'h0F0F_0F0F; m0_bus.sel = 4'hF;
    s_bus.ack = 1; s_bus.rdata = 32'hDEAD_BEEF;
    tick();
    #1;
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++;
    if ({s_bus.cyc, s_bus.stb, s_bus.we} !== 3'b000) begin failures++; $display("FAIL reset_s_ctrl: got %b want 000", {s_bus.cyc, s_bus.stb, s_bus.we}); end
    checks++;
    if ({s_bus.addr, s_bus.wdata, s_bus.sel} !== 68'h0) begin failures++; $display("FAIL reset_s_data: got %h want 0", {s_bus.addr, s_bus.wdata, s_bus.sel}); end
    checks++;
    if ({m0_bus.stall, m1_bus.stall} !== 2'b11) begin failures++; $display("FAIL reset_stall: got %b want 11", {m0_bus.stall, m1_bus.stall}); end
    checks++;
    if ({m0_bus.ack, m0_bus.err, m0_bus.rty, m1_bus.ack, m1_bus.err, m1_bus.rty} !== 6'b0) begin
      failures++; $display("FAIL reset_resp: got %b want 000000", {m0_bus.ack, m0_bus.err, m0_bus.rty, m1_bus.ack, m1_bus.err, m1_bus.rty});
    end
    checks++;
    if ({m0_bus.rdata, m1_bus.rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", {m0_bus.rdata, m1_bus.rdata}); end
    idle_inputs();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_pipelined_reads();
    int          issued = 0;
    int          acked  = 0;
    int          due[$];
    logic [31:0] dq[$];
    logic [31:0] exp;
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.we = 0; m0_bus.sel = 4'hF; m0_bus.addr = 32'h8000_0000;
    #1;
    checks++;
    if (grant !== 2'b00 || m0_bus.stall !== 1'b1) begin failures++; $display("FAIL arb_latency: grant %b stall %b want 00 1", grant, m0_bus.stall); end
    tick();
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL grant_m0: got %b want 01", grant); end
    for (int c = 0; c < 14; c++) begin
      s_bus.ack = 0; s_bus.rdata = '0;
      if (due.size() > 0 && due[0] == c) begin
        s_bus.ack = 1; s_bus.rdata = dq.pop_front(); void'(due.pop_front());
      end
      m0_bus.stb  = (issued < 4);
      m0_bus.addr = 32'h8000_0000 + 32'(issued * 4);
      #1;
      checks++;
      if (m1_bus.stall !== 1'b1) begin failures++; $display("FAIL m1_stall_c%0d: got %b want 1", c, m1_bus.stall); end
      if (s_bus.ack) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (m0_bus.ack !== 1'b1 || m0_bus.rdata !== exp) begin
          failures++; $display("FAIL read_ack_c%0d: ack %b rdata %h want 1 %h", c, m0_bus.ack, m0_bus.rdata, exp);
        end
        acked++;
      end
      if (m0_bus.stb && !m0_bus.stall) begin
        exp_q.push_back((32'h8000_0000 + 32'(issued * 4)) ^ 32'h5A5A_0000);
        issued++;
      end
      if (s_bus.stb && !s_bus.stall) begin
        due.push_back(c + 3);
        dq.push_back(s_bus.addr ^ 32'h5A5A_0000);
      end
      tick();
    end
    checks++;
    if (acked != 4 || issued != 4 || exp_q.size() != 0) begin
      failures++; $display("FAIL read_count: acked %0d issued %0d left %0d want 4 4 0", acked, issued, exp_q.size());
    end
    s_bus.ack = 0;
    m0_bus.cyc = 0; m0_bus.stb = 0;
    #1;
    checks++;
    if (s_bus.cyc !== 1'b0) begin failures++; $display("FAIL release_comb: s cyc %b want 0", s_bus.cyc); end
    tick();
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL release_idle: got %b want 00", grant); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    m0_bus.cyc = 1; m1_bus.cyc = 1;
    tick();
    checks++;
    if (grant !== 2'b01 || m1_bus.stall !== 1'b1) begin failures++; $display("FAIL rr_first: grant %b m1 stall %b want 01 1", grant, m1_bus.stall); end
    m0_bus.cyc = 0;
    #1;
    checks++;
    if (s_bus.cyc !== 1'b0) begin failures++; $display("FAIL rr_drop: s cyc %b want 0", s_bus.cyc); end
    tick();
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL rr_gap: got %b want 00", grant); end
    tick();
    checks++;
    if (grant !== 2'b10 || s_bus.cyc !== 1'b1) begin failures++; $display("FAIL rr_second: grant %b s cyc %b want 10 1", grant, s_bus.cyc); end
    m0_bus.cyc = 1; m1_bus.cyc = 0;
    tick();
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL rr_gap2: got %b want 00", grant); end
    m1_bus.cyc = 1;
    tick();
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL rr_third: got %b want 01", grant); end
    m0_bus.cyc = 0; m1_bus.cyc = 0;
    repeat (2) tick();
  endtask

  task automatic test_outstanding_limit();
    int acc = 0;
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.we = 1; m0_bus.sel = 4'hF;
    tick();
    for (int i = 0; i < 8; i++) begin
      m0_bus.addr = 32'h8000_1000 + 32'(i * 4); m0_bus.wdata = 32'hA000_0000 + 32'(i);
      #1;
      if (s_bus.stb && !m0_bus.stall) acc++;
      if (i == 3) begin
        checks++;
        if (s_bus.we !== 1'b1 || s_bus.wdata !== 32'hA000_0003) begin failures++; $display("FAIL wr_pass: we %b wdata %h want 1 a0000003", s_bus.we, s_bus.wdata); end
      end
      tick();
    end
    checks++;
    if (acc != 8) begin failures++; $display("FAIL wr_accepted: got %0d want 8", acc); end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (m0_bus.stall !== 1'b1 || s_bus.stb !== 1'b0) begin failures++; $display("FAIL full_hold%0d: stall %b stb %b want 1 0", i, m0_bus.stall, s_bus.stb); end
      tick();
    end
    s_bus.ack = 1;
    #1;
    checks++;
    if (m0_bus.stall !== 1'b1 || m0_bus.ack !== 1'b1) begin failures++; $display("FAIL full_ack: stall %b ack %b want 1 1", m0_bus.stall, m0_bus.ack); end
    tick();
    s_bus.ack = 0;
    #1;
    checks++;
    if (m0_bus.stall !== 1'b0 || s_bus.stb !== 1'b1) begin failures++; $display("FAIL ninth_accept: stall %b stb %b want 0 1", m0_bus.stall, s_bus.stb); end
    tick();
    #1;
    checks++;
    if (m0_bus.stall !== 1'b1 || s_bus.stb !== 1'b0) begin failures++; $display("FAIL refull: stall %b stb %b want 1 0", m0_bus.stall, s_bus.stb); end
    m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0;
    repeat (2) tick();
  endtask

  task automatic test_abort_stale();
    m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.addr = 32'h8000_0100;
    tick();
    checks++;
    if (grant !== 2'b10) begin failures++; $display("FAIL abort_grant1: got %b want 10", grant); end
    for (int i = 0; i < 2; i++) begin
      m1_bus.addr = 32'h8000_0100 + 32'(i * 4);
      #1;
      checks++;
      if (!(s_bus.stb && !m1_bus.stall)) begin failures++; $display("FAIL abort_issue%0d: stb %b stall %b want 1 0", i, s_bus.stb, m1_bus.stall); end
      tick();
    end
    m1_bus.stb = 0; m1_bus.cyc = 0; m0_bus.cyc = 1; m0_bus.stb = 0;
    tick();
    s_bus.ack = 1; s_bus.rdata = 32'h5555_0001;
    #1;
    checks++;
    if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin failures++; $display("FAIL stale_idle: m0 ack %b m1 ack %b want 0 0", m0_bus.ack, m1_bus.ack); end
    tick();
    s_bus.rdata = 32'h5555_0002;
    #1;
    checks++;
    if (grant !== 2'b01 || m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin
      failures++; $display("FAIL stale_grant: grant %b m0 ack %b m1 ack %b want 01 0 0", grant, m0_bus.ack, m1_bus.ack);
    end
    tick();
    s_bus.ack = 0; m0_bus.stb = 1; m0_bus.addr = 32'h8000_0200;
    #1;
    checks++;
    if (!(s_bus.stb && !m0_bus.stall) || s_bus.addr !== 32'h8000_0200) begin failures++; $display("FAIL post_abort_issue: stb %b addr %h want 1 80000200", s_bus.stb, s_bus.addr); end
    tick();
    m0_bus.stb = 0;
    tick();
    s_bus.ack = 1; s_bus.rdata = 32'hCAFE_0001;
    #1;
    checks++;
    if (m0_bus.ack !== 1'b1 || m0_bus.rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL post_abort_read: ack %b rdata %h want 1 cafe0001", m0_bus.ack, m0_bus.rdata); end
    tick();
    s_bus.ack = 0; m0_bus.cyc = 0;
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.addr = 32'h8000_0300;
    tick();
    #1;
    checks++;
    if (s_bus.cyc !== 1'b1) begin failures++; $display("FAIL pre_reset_cyc: got %b want 1", s_bus.cyc); end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0 || s_bus.addr !== 32'h0) begin
      failures++; $display("FAIL async_reset_s: cyc %b stb %b addr %h want 0 0 0", s_bus.cyc, s_bus.stb, s_bus.addr);
    end
    checks++;
    if (grant !== 2'b00 || m0_bus.stall !== 1'b1) begin failures++; $display("FAIL async_reset_m: grant %b stall %b want 00 1", grant, m0_bus.stall); end
    idle_inputs();
    tick();
    rstn = 1'b1;
    tick();
    m0_bus.cyc = 1; m1_bus.cyc = 1;
    tick();
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL post_reset_grant: got %b want 01", grant); end
    m0_bus.cyc = 0; m1_bus.cyc = 0;
    repeat (2) tick();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.addr = 32'h8000_0400;
    tick();
    #1;
    checks++;
    if (!(s_bus.stb && !m0_bus.stall)) begin failures++; $display("FAIL to_issue: stb %b stall %b want 1 0", s_bus.stb, m0_bus.stall); end
    tick();
    m0_bus.stb = 0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      checks++;
      if (k < 16) begin
        if (m0_bus.err !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL to_early_k%0d: err %b timeout %b want 0 0", k, m0_bus.err, timeout); end
        tick();
      end else begin
        if (m0_bus.err !== 1'b1 || timeout !== 1'b1 || s_bus.cyc !== 1'b0) begin
          failures++; $display("FAIL to_fire: err %b timeout %b s cyc %b want 1 1 0", m0_bus.err, timeout, s_bus.cyc);
        end
      end
    end
    tick();
    checks++;
    if (grant !== 2'b00 || timeout !== 1'b0) begin failures++; $display("FAIL to_idle: grant %b timeout %b want 00 0", grant, timeout); end
    m0_bus.cyc = 0;
    repeat (2) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_pipelined_reads();
    test_round_robin();
    test_outstanding_limit();
    test_abort_stale();
    test_async_reset();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
